// File: rtl/spi_burst_slave.sv
`default_nettype none
// =============================================================================
// Module   : spi_burst_slave
// Function : SPI mode-0 slave, header (cmd+len) then burst of data words per
//            frame, full-duplex response FIFO on MISO.
// Options  : SPI_BURST_STATUS_EN - shift a status word on MISO during IDLE/HDR
// Revision : 1.0 - initial release
// =============================================================================
module spi_burst_slave #(
   parameter int CMD_W       = 8,
   parameter int LEN_W       = 4,
   parameter int DATA_W      = 8,
   parameter int RFIFO_DEPTH = 4
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              hdr_valid,
   output logic [CMD_W-1:0]  hdr_cmd,
   output logic [LEN_W-1:0]  hdr_len,
   output logic              wr_valid,
   output logic [DATA_W-1:0] wr_data,
   output logic [LEN_W-1:0]  wr_idx,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              rsp_ready,
   output logic [1:0]        err,
   input  logic              err_clr,
   output logic              busy
);

   localparam int H      = CMD_W + LEN_W;
   localparam int LVL_W  = $clog2(RFIFO_DEPTH) + 1;
   localparam int PTR_W  = $clog2(RFIFO_DEPTH);
   localparam int SH_W   = (H > DATA_W) ? H : DATA_W;
   localparam int BCNT_W = $clog2(SH_W);
   localparam logic [BCNT_W-1:0] HDR_LAST  = BCNT_W'(H - 1);
   localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_W - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(RFIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
   logic [SH_W-1:0]     sh_q, sh_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic                hdr_valid_q, hdr_valid_d;
   logic [CMD_W-1:0]    hdr_cmd_q, hdr_cmd_d;
   logic [LEN_W-1:0]    hdr_len_q, hdr_len_d;
   logic                wr_valid_q, wr_valid_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [LEN_W-1:0]    wr_idx_q, wr_idx_d;
   logic [1:0]          err_q, err_d;
   logic                miso_q;

   logic [DATA_W-1:0]   mem_q [RFIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
   logic [LVL_W-1:0]    level_q;

   logic [SH_W-1:0]     w_sh;
   logic                w_pop, w_push, w_urun, w_abort;

   assign w_sh   = {sh_q[SH_W-2:0], mosi};
   assign w_push = rsp_valid && (level_q != LVL_FULL);
   assign w_urun = w_pop && (level_q == '0);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      word_cnt_d  = word_cnt_q;
      sh_d        = sh_q;
      tx_d        = tx_q;
      hdr_valid_d = 1'b0;
      hdr_cmd_d   = hdr_cmd_q;
      hdr_len_d   = hdr_len_q;
      wr_valid_d  = 1'b0;
      wr_data_d   = wr_data_q;
      wr_idx_d    = wr_idx_q;
      w_pop       = 1'b0;
      w_abort     = 1'b0;
      if (cs_n) begin
         state_d    = S_IDLE;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         w_abort    = (state_q == S_HDR) || ((state_q == S_DATA) && (bit_cnt_q != '0));
      end else begin
         case (state_q)
            S_IDLE: begin
               sh_d      = w_sh;
               bit_cnt_d = BCNT_W'(1);
               state_d   = S_HDR;
            end
            S_HDR: begin
               sh_d = w_sh;
               if (bit_cnt_q == HDR_LAST) begin
                  hdr_valid_d = 1'b1;
                  hdr_cmd_d   = w_sh[H-1:LEN_W];
                  hdr_len_d   = w_sh[LEN_W-1:0];
                  bit_cnt_d   = '0;
                  word_cnt_d  = '0;
                  if (w_sh[LEN_W-1:0] == '0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_DATA;
                     w_pop   = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end
            end
            S_DATA: begin
               sh_d = w_sh;
               tx_d = {tx_q[DATA_W-2:0], 1'b0};
               if (bit_cnt_q == DATA_LAST) begin
                  wr_valid_d = 1'b1;
                  wr_data_d  = w_sh[DATA_W-1:0];
                  wr_idx_d   = word_cnt_q;
                  bit_cnt_d  = '0;
                  if (word_cnt_q == hdr_len_q - LEN_W'(1)) begin
                     state_d = S_DONE;
                  end else begin
                     word_cnt_d = word_cnt_q + LEN_W'(1);
                     w_pop      = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
      // An empty FIFO answers with all-ones rather than stale data
      if (w_pop) tx_d = (level_q != '0) ? mem_q[rd_ptr_q] : '1;
      err_d = err_clr ? 2'b00 : err_q;
      err_d = err_d | {w_urun, w_abort};
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         sh_q        <= '0;
         tx_q        <= '0;
         hdr_valid_q <= 1'b0;
         hdr_cmd_q   <= '0;
         hdr_len_q   <= '0;
         wr_valid_q  <= 1'b0;
         wr_data_q   <= '0;
         wr_idx_q    <= '0;
         err_q       <= 2'b00;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         sh_q        <= sh_d;
         tx_q        <= tx_d;
         hdr_valid_q <= hdr_valid_d;
         hdr_cmd_q   <= hdr_cmd_d;
         hdr_len_q   <= hdr_len_d;
         wr_valid_q  <= wr_valid_d;
         wr_data_q   <= wr_data_d;
         wr_idx_q    <= wr_idx_d;
         err_q       <= err_d;
         if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (w_pop && !w_urun) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (w_push && !(w_pop && !w_urun)) level_q <= level_q + LVL_W'(1);
         else if (!w_push && w_pop && !w_urun) level_q <= level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge sclk) begin
      if (w_push) mem_q[wr_ptr_q] <= rsp_data;
   end

`ifdef SPI_BURST_STATUS_EN
   logic [H-1:0] stat_q;
   logic [H-1:0] w_status;
   assign w_status = {err_q[1], err_q[0], level_q, {(H-2-LVL_W){1'b0}}};

   // IDLE keeps re-snapshotting so the word seen in HDR is the one at frame start
   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         miso_q <= 1'b0;
         stat_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               stat_q <= w_status;
               miso_q <= w_status[H-1];
            end
            S_HDR: begin
               stat_q <= {stat_q[H-2:0], 1'b0};
               miso_q <= stat_q[H-2];
            end
            S_DATA:  miso_q <= tx_q[DATA_W-1];
            default: miso_q <= 1'b0;
         endcase
      end
   end
`else
   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         miso_q <= 1'b0;
      end else begin
         miso_q <= (state_q == S_DATA) ? tx_q[DATA_W-1] : 1'b0;
      end
   end
`endif

   assign miso      = miso_q;
   assign hdr_valid = hdr_valid_q;
   assign hdr_cmd   = hdr_cmd_q;
   assign hdr_len   = hdr_len_q;
   assign wr_valid  = wr_valid_q;
   assign wr_data   = wr_data_q;
   assign wr_idx    = wr_idx_q;
   assign rsp_ready = (level_q != LVL_FULL);
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/spi_burst_slave.md
# spi_burst_slave

Parametrised SPI mode-0 slave front end that replaces the fixed 24-bit single-transaction receiver in the NPU host link. It accepts a header (command + burst length) followed by a variable-length burst of data words in one chip-select frame. In full duplex, it returns words from an internal response FIFO on MISO. Everything runs in the sclk domain; the core-side clock-domain crossing sits downstream in a separate block.

## Interface
Parameters:
- CMD_W, 8, command field width
- LEN_W, 4, burst-length field width; header width H = CMD_W+LEN_W
- DATA_W, 8, data/response word width
- RFIFO_DEPTH, 4, response FIFO depth, power of 2, ≥2; LVL_W = $clog2(RFIFO_DEPTH)+1

Ports:
- sclk  in  1  SPI clock; logic on rising edge, MISO register on falling edge
- rst_n  in  1  asynchronous, active-low reset
- cs_n  in  1  chip select, active low, sampled on sclk rising edge
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out, MSB first
- hdr_valid  out  1  one-cycle pulse: header captured
- hdr_cmd  out  CMD_W  captured command
- hdr_len  out  LEN_W  captured burst length (words)
- wr_valid  out  1  one-cycle pulse per received data word
- wr_data  out  DATA_W  received word
- wr_idx  out  LEN_W  word index within burst, 0-based
- rsp_valid  in  1  response push request
- rsp_data  in  DATA_W  response word
- rsp_ready  out  1  FIFO not full
- err  out  2  sticky {urun, abort}
- err_clr  in  1  synchronous clear of err
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, HDR, DATA, DONE.
- Any state, cs_n=1 at a rising edge:
  - Go to IDLE and clear the bit and word counters.
  - If the state was HDR, or DATA with a partial word, set err[0] (abort). No pulses are emitted.
- Host contract: at least one sclk rising edge with cs_n=1 between frames.
- IDLE, cs_n=0: shift mosi in as header bit 0 and go to HDR.
- HDR:
  - Shift H bits.
  - On the rising edge sampling bit H-1, latch hdr_cmd and hdr_len and pulse hdr_valid.
  - If len=0, go to DONE. Otherwise go to DATA and pop the FIFO head into the tx shifter.
- DATA:
  - On each DATA_W-th bit, drive wr_data and wr_idx and pulse wr_valid.
  - After word hdr_len-1, go to DONE. Otherwise pop the next response word.
- DONE: ignore mosi, drive miso=0, and wait for cs_n=1.
- Pop from an empty FIFO: load all-ones into the tx shifter and set err[1] (urun).
- Response FIFO:
  - Push when rsp_valid && rsp_ready; rsp_ready = (level < RFIFO_DEPTH).
  - A push and pop on the same edge with level 0 counts as underflow; there is no bypass.
  - A push and pop on the same edge when partially full leaves level unchanged.
- err_clr clears err on the same edge. A simultaneous new error event wins and sets its bit.
- The FIFO contents persist across frames. Only rst_n flushes them.

## Timing
- Reset values: miso=0, hdr_valid=0, hdr_cmd=0, hdr_len=0, wr_valid=0, wr_data=0, wr_idx=0, rsp_ready=1, err=0, busy=0, FIFO level 0, state IDLE.
- hdr_valid and wr_valid are registered. Each is high for exactly one sclk period, starting at the edge that completes the field.
- miso is updated on falling edges, so the value for rising edge n is set up by falling edge n-1.
- The response word MSB appears at the falling edge after the header-completing rising edge, aligned with the first data bit.
- Data word k on MISO is aligned with data word k on MOSI.
- Latency: bit in to wr_valid is 0 cycles after the last word bit (registered output at that edge).

## Configuration
- SPI_BURST_STATUS_EN defined:
  - During IDLE and HDR, miso shifts out an H-bit status word, MSB first: {urun, abort, level[LVL_W-1:0], zeros}.
  - In IDLE the MISO register continuously holds status bit H-1.
  - The status snapshot is taken at the falling edge before header bit 0.
- Not defined: miso=0 in IDLE and HDR.

## Test plan
Defaults apply to all scenarios.
- Basic burst:
  - Stimulus: preload FIFO with 0x11, 0x22; send header cmd=0xA5, len=2, then data 0x3C, 0xC3.
  - Response: hdr_valid at edge 12 (cmd 0xA5, len 2). wr_valid at edge 20 (idx0, 0x3C) and edge 28 (idx1, 0xC3). miso carries 0x11 over bits 12-19 and 0x22 over bits 20-27. err=0.
- Zero-length burst:
  - Stimulus: header cmd=0x01, len=0, then 8 extra clocks.
  - Response: hdr_valid once, no wr_valid, miso=0 in DONE, FIFO level unchanged.
- Underflow:
  - Stimulus: empty FIFO; header len=1, data 0x5A.
  - Response: miso=0xFF, wr_data=0x5A, err=2'b10. err_clr on the next edge gives err=0.
- Abort:
  - Stimulus: cs_n raised after 17 bits of a len=2 frame.
  - Response: one hdr_valid, no wr_valid, err=2'b01, busy=0. The next frame decodes normally.
- FIFO full:
  - Stimulus: push 5 words with rsp_valid held high.
  - Response: rsp_ready falls after 4 pushes and the 5th word is dropped. A simultaneous push and pop at level 2 keeps level 2.
- With SPI_BURST_STATUS_EN:
  - Stimulus: FIFO level 3, err=2'b10.
  - Response: header-phase miso is 12'b1_0_011_0000000.
